// File: rtl/alu_pkg.sv
// Shared ALU constants: operand width, select codes, sequencer states and the
// single-cycle result helper used by the execution unit and the result mux.
package alu_pkg;

  localparam int WIDTH = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SLTI = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] s);
    return (s == OP_SLL) || (s == OP_SRA);
  endfunction

  // Shifts return A unchanged here, which is the correct result for a zero shift.
  function automatic logic [WIDTH-1:0] imm_result(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [3:0]       s);
    logic [WIDTH-1:0] r;
    case (s)
      OP_SLTI:        r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL, OP_SRA: r = a;
      OP_ADD:         r = a + b;
      default:        r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shifter: dir=0 shifts left with zero fill, dir=1 shifts
// right filling with the sign bit when arith=1, otherwise with zero.
module alu_shift_step
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] din,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    if (dir) begin
      dout = {(arith & din[WIDTH-1]), din[WIDTH-1:1]};
    end else begin
      dout = {din[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Multi-cycle ALU unit (add/slti/sll/sra): latency 1, or 1+k for shifts by k unless ALU_FAST_SHIFT_EN.
// Result is held in DONE until Dalja_ready; Hyrja_ready is low outside IDLE.
module alu_seq_exec
  import alu_pkg::*;
(
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Hyrja_valid,
  output logic             Hyrja_ready,
  input  logic [WIDTH-1:0] Hyrja_A,
  input  logic [WIDTH-1:0] Hyrja_B,
  input  logic [3:0]       S,
  output logic             Dalja_valid,
  input  logic             Dalja_ready,
  output logic [WIDTH-1:0] Dalja,
  output logic [3:0]       Dalja_S,
  output logic             Busy
);

  state_t           state, state_nxt;
  logic             accept;
  logic             long_shift;
  logic             shift_done;
  logic [WIDTH-1:0] dalja_q;
  logic [3:0]       dalja_s_q;

  assign accept = Hyrja_valid & Hyrja_ready;

`ifdef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] fast_res;

  always_comb begin
    fast_res = imm_result(Hyrja_A, Hyrja_B, S);
    if (S == OP_SLL) begin
      fast_res = Hyrja_A << Hyrja_B[3:0];
    end else if (S == OP_SRA) begin
      fast_res = $signed(Hyrja_A) >>> Hyrja_B[3:0];
    end
  end

  assign long_shift = 1'b0;
  assign shift_done = 1'b0;

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      dalja_q   <= '0;
      dalja_s_q <= '0;
    end else if (accept) begin
      dalja_q   <= fast_res;
      dalja_s_q <= S;
    end
  end
`else
  logic [WIDTH-1:0] work, work_step;
  logic [3:0]       cnt;
  logic             is_sra;

  // Dalja_S already holds the latched select while shifting.
  assign is_sra     = (dalja_s_q == OP_SRA);
  assign long_shift = is_shift(S) && (Hyrja_B[3:0] != 4'd0);
  assign shift_done = (state == SHIFT) && (cnt == 4'd1);

  alu_shift_step u_step (
    .din   (work),
    .dir   (is_sra),
    .arith (is_sra),
    .dout  (work_step)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      dalja_q   <= '0;
      dalja_s_q <= '0;
      work      <= '0;
      cnt       <= '0;
    end else if (accept) begin
      dalja_s_q <= S;
      if (long_shift) begin
        work <= Hyrja_A;
        cnt  <= Hyrja_B[3:0];
      end else begin
        dalja_q <= imm_result(Hyrja_A, Hyrja_B, S);
      end
    end else if (state == SHIFT) begin
      work <= work_step;
      cnt  <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        dalja_q <= work_step;
      end
    end
  end
`endif

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = long_shift ? SHIFT : DONE;
      SHIFT:   if (shift_done) state_nxt = DONE;
      DONE:    if (Dalja_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Hyrja_ready = (state == IDLE);
    Dalja_valid = (state == DONE);
    Busy        = (state != IDLE);
  end

  assign Dalja   = dalja_q;
  assign Dalja_S = dalja_s_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Bench for alu_seq_exec: directed cases from the unit's rules plus random ops
// checked against an arithmetic reference model for result and latency.
module tb_alu_seq_exec;
  import alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Hyrja_valid = 1'b0;
  logic        Hyrja_ready;
  logic [15:0] Hyrja_A = '0;
  logic [15:0] Hyrja_B = '0;
  logic [3:0]  S = '0;
  logic        Dalja_valid;
  logic        Dalja_ready = 1'b0;
  logic [15:0] Dalja;
  logic [3:0]  Dalja_S;
  logic        Busy;

  int checks = 0;
  int failures = 0;

  alu_seq_exec dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .Hyrja_valid (Hyrja_valid),
    .Hyrja_ready (Hyrja_ready),
    .Hyrja_A     (Hyrja_A),
    .Hyrja_B     (Hyrja_B),
    .S           (S),
    .Dalja_valid (Dalja_valid),
    .Dalja_ready (Dalja_ready),
    .Dalja       (Dalja),
    .Dalja_S     (Dalja_S),
    .Busy        (Busy)
  );

  always #5 Clock = ~Clock;

  function automatic logic [15:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [3:0] s);
    int k, sa, sb, ua, d, q;
    k  = int'(b[3:0]);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    d  = 1 << k;
    case (s)
      4'b0001: return (sa < sb) ? 16'h0001 : 16'h0000;
      4'b0110: return 16'((ua * d) % 65536);
      4'b0111: begin
        // floor division by 2^k
        if (sa >= 0) q = sa / d;
        else         q = -((-sa + d - 1) / d);
        return 16'(q);
      end
      default: return 16'((ua + int'(b)) % 65536);
    endcase
  endfunction

  function automatic int ref_latency(input logic [15:0] b, input logic [3:0] s);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if ((s == 4'b0110 || s == 4'b0111) && b[3:0] != 4'd0) return 1 + int'(b[3:0]);
    return 1;
`endif
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s,
                        input bit hold_ready, input string name);
    int lat, waitc, exp_lat;
    logic [15:0] exp;
    exp = ref_result(a, b, s);
    exp_lat = ref_latency(b, s);
    waitc = 0;
    while (!Hyrja_ready && waitc < 50) begin
      step();
      waitc++;
    end
    Hyrja_A = a; Hyrja_B = b; S = s;
    Hyrja_valid = 1'b1;
    Dalja_ready = hold_ready;
    step();
    Hyrja_valid = 1'b0;
    lat = 1;
    while (!Dalja_valid && lat < 40) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
    end
    checks++;
    if (Dalja !== exp) begin
      failures++;
      $display("FAIL %s result A=%h B=%h S=%b got=%h want=%h", name, a, b, s, Dalja, exp);
    end
    checks++;
    if (Dalja_S !== s) begin
      failures++;
      $display("FAIL %s select got=%b want=%b", name, Dalja_S, s);
    end
    Dalja_ready = 1'b1;
    step();
    Dalja_ready = 1'b0;
    checks++;
    if (Dalja_valid !== 1'b0 || Hyrja_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release valid=%b ready=%b want valid=0 ready=1", name, Dalja_valid, Hyrja_ready);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    step();
    step();
    checks++;
    if ({Dalja_valid, Dalja, Dalja_S, Busy} !== {1'b0, 16'h0000, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_state valid=%b dalja=%h s=%b busy=%b want 0/0000/0000/0",
               Dalja_valid, Dalja, Dalja_S, Busy);
    end
    Resetn = 1'b1;
    step();
    checks++;
    if (Hyrja_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", Hyrja_ready);
    end
  endtask

  task automatic test_add();
    run_op(16'hFFFF, 16'h0002, 4'b0000, 1'b0, "add");
    run_op(16'hFFFF, 16'h0002, 4'b1010, 1'b0, "add_undef1010");
    run_op(16'h1234, 16'h4321, 4'b1111, 1'b1, "add_undef1111");
  endtask

  task automatic test_slti();
    run_op(16'hFFFE, 16'h0001, 4'b0001, 1'b0, "slti_neg");
    run_op(16'h0005, 16'hFFFF, 4'b0001, 1'b0, "slti_pos");
    run_op(16'h7FFF, 16'h7FFF, 4'b0001, 1'b0, "slti_eq");
  endtask

  task automatic test_shift();
    run_op(16'h8000, 16'h000F, 4'b0111, 1'b0, "sra15");
    run_op(16'h0001, 16'h0004, 4'b0110, 1'b0, "sll4");
    run_op(16'hA5A5, 16'h0010, 4'b0110, 1'b0, "sll0");
    run_op(16'h8001, 16'hFFF1, 4'b0111, 1'b1, "sra1_hold");
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    run_op_start(16'h0100, 16'h0023);
    held = Dalja;
    Hyrja_A = 16'h0003; Hyrja_B = 16'h0004; S = 4'b0000;
    Hyrja_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (Dalja_valid !== 1'b1 || Hyrja_ready !== 1'b0 || Dalja !== held || Dalja !== 16'h0123) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d valid=%b ready=%b dalja=%h want 1/0/0123", i,
                 Dalja_valid, Hyrja_ready, Dalja);
      end
    end
    Dalja_ready = 1'b1;
    step();
    Dalja_ready = 1'b0;
    checks++;
    if (Dalja_valid !== 1'b0 || Hyrja_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release valid=%b ready=%b want 0/1", Dalja_valid, Hyrja_ready);
    end
    step();
    Hyrja_valid = 1'b0;
    checks++;
    if (Dalja_valid !== 1'b1 || Dalja !== 16'h0007) begin
      failures++;
      $display("FAIL bp_next valid=%b dalja=%h want 1/0007", Dalja_valid, Dalja);
    end
    Dalja_ready = 1'b1;
    step();
    Dalja_ready = 1'b0;
  endtask

  // Issue an add and leave the result sitting in DONE with Dalja_ready low.
  task automatic run_op_start(input logic [15:0] a, input logic [15:0] b);
    Hyrja_A = a; Hyrja_B = b; S = 4'b0000;
    Hyrja_valid = 1'b1;
    step();
    Hyrja_valid = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int seen;
    Hyrja_A = 16'h0001; Hyrja_B = 16'h000A; S = 4'b0110;
    Hyrja_valid = 1'b1;
    step();
    Hyrja_valid = 1'b0;
    step();
    step();
`ifndef ALU_FAST_SHIFT_EN
    checks++;
    if (Busy !== 1'b1 || Dalja_valid !== 1'b0) begin
      failures++;
      $display("FAIL midshift_busy busy=%b valid=%b want 1/0", Busy, Dalja_valid);
    end
`endif
    Resetn = 1'b0;
    step();
    Resetn = 1'b1;
    checks++;
    if (Busy !== 1'b0 || Hyrja_ready !== 1'b1 || Dalja_valid !== 1'b0) begin
      failures++;
      $display("FAIL midshift_abort busy=%b ready=%b valid=%b want 0/1/0", Busy, Hyrja_ready, Dalja_valid);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (Dalja_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midshift_noresult valid_cycles got=%0d want=0", seen);
    end
    run_op(16'h0010, 16'h0020, 4'b0000, 1'b0, "post_reset_add");
  endtask

  task automatic test_back_to_back();
    Hyrja_A = 16'h0F0F; Hyrja_B = 16'h0101; S = 4'b0000;
    Hyrja_valid = 1'b1;
    Dalja_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (Dalja_valid !== ((i % 2) == 0) || (Dalja_valid && Dalja !== 16'h1010)) begin
        failures++;
        $display("FAIL b2b cyc=%0d valid=%b dalja=%h want valid=%0d dalja=1010", i,
                 Dalja_valid, Dalja, (i % 2) == 0);
      end
    end
    Hyrja_valid = 1'b0;
    step();
    Dalja_ready = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [3:0]  s;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 3))
        0: s = 4'b0110;
        1: s = 4'b0111;
        2: s = 4'b0001;
        default: s = 4'($urandom);
      endcase
      run_op(a, b, s, 1'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_slti();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle ALU execution unit producing the four results (sum, slti, sll, sra) selected by the 16-bit CPU's 4-bit ALU select code. Sits between the decode stage and the ALU result multiplexer; it accepts an operation over a valid/ready handshake, computes it (iteratively for shifts), and presents the result with the select code that produced it to the result path and writeback.

## Interface
- WIDTH, 16: operand/result width; shift amount is B[3:0].
- Clock  in  1  rising-edge clock.
- Resetn  in  1  synchronous active-low reset.
- Hyrja_valid  in  1  operation request valid.
- Hyrja_ready  out  1  unit can accept a request.
- Hyrja_A  in  WIDTH  operand A.
- Hyrja_B  in  WIDTH  operand B / immediate; shifts use B[3:0].
- S  in  4  select: 0001 slti, 0110 sll, 0111 sra, any other value add.
- Dalja_valid  out  1  result valid.
- Dalja_ready  in  1  consumer accepts result.
- Dalja  out  WIDTH  result.
- Dalja_S  out  4  select code of the operation that produced Dalja.
- Busy  out  1  high in any state other than IDLE.

## Operation
- Clock and reset: one clock; reset is synchronous and active-low; Resetn sampled on rising edge of Clock.
- States: IDLE, SHIFT, DONE.
- IDLE: Hyrja_ready=1. On Hyrja_valid: latch A, B[3:0] as shift counter, S.
  - add (default codes): Dalja <= A+B mod 2^16, carry discarded -> DONE.
  - slti: Dalja <= 16'h0001 if $signed(A) < $signed(B), else 16'h0000 -> DONE.
  - sll/sra with B[3:0]=0: Dalja <= A -> DONE.
  - sll/sra with B[3:0]≠0: working reg <= A -> SHIFT.
- SHIFT: each cycle shift working reg one bit (sll: zero-fill LSB; sra: replicate bit 15), decrement counter; when counter reaches 0 after the shift, load Dalja -> DONE.
- DONE: Dalja_valid=1; Dalja, Dalja_S stable until Dalja_ready=1, then -> IDLE.
- Hyrja_ready=0 in SHIFT and DONE; requests presented then are not accepted and must be held by the producer.
- Undefined select codes (e.g. 0010, 1111) execute as add, matching the result mux default.

## Timing
- Reset values: Hyrja_ready=1 (after reset release), Dalja_valid=0, Dalja=16'h0000, Dalja_S=4'b0000, Busy=0, state IDLE. Reset asserted in any state aborts the operation without producing a result.
- Accept at edge N (Hyrja_valid & Hyrja_ready): add/slti/shift-by-0 -> Dalja_valid high from edge N+1; shift by k (1..15) -> Dalja_valid high from edge N+1+k.
- Dalja_valid and Dalja_ready high at edge M -> Dalja_valid low and Hyrja_ready high from M+1; next accept earliest at M+1. Minimum issue interval: 2 cycles.
- Dalja_ready is ignored outside DONE; Dalja_ready held high does not shorten latency.

## Configuration
- ALU_FAST_SHIFT_EN defined: shifts computed in IDLE by a single-cycle barrel shifter; SHIFT state unused; all operations have latency 1.
- Not defined: iterative 1-bit/cycle shifter as above, latency 1+k.
- Results are identical either way; only latency differs.

## Structure
- Shared package alu_pkg: WIDTH=16, select constants OP_SLTI=4'b0001, OP_SLL=4'b0110, OP_SRA=4'b0111, OP_ADD=4'b0000, state enum {IDLE, SHIFT, DONE}; the decoder and result multiplexer use the same constants.
- One sub-module alu_shift_step: combinational one-bit shift (dir/arith inputs); instanced in the iterative build, barrel shift is inline when ALU_FAST_SHIFT_EN is defined.

## Test plan
- Reset: Resetn=0 for 2 cycles -> Dalja_valid=0, Dalja=0000, Dalja_S=0000, Busy=0; Hyrja_ready=1 after release.
- Add: A=FFFF, B=0002, S=0000 -> Dalja=0001, Dalja_S=0000 one cycle after accept; S=1010 gives the same result.
- slti signed: A=FFFE, B=0001, S=0001 -> 0001; A=0005, B=FFFF -> 0000.
- sra: A=8000, B=000F, S=0111 -> Dalja=FFFF, valid 16 cycles after accept (1 with ALU_FAST_SHIFT_EN); sll A=0001, B=0004 -> 0010 after 5 cycles.
- Backpressure: Dalja_ready=0 for 5 cycles in DONE -> Dalja stable, Hyrja_ready=0, new Hyrja_valid not accepted; accepted the cycle after Dalja_ready=1.
- Reset mid-shift: Resetn=0 during SHIFT of sll by 10 -> no Dalja_valid, IDLE next cycle, next add completes normally.
